// File: rtl/pc_if.sv
// Fetch-redirect bus between the pipeline (master) and the PC owner (slave).
// Carries jr_req/jr_address only when PC_JR_EN is defined.
interface pc_if #(
  parameter int unsigned len_data = 32
) ();
  logic                enable;
  logic                stall;
  logic                branch_taken;
  logic [len_data-1:0] branch_address;
  logic                jump_req;
  logic [len_data-1:0] jump_address;
`ifdef PC_JR_EN
  logic                jr_req;
  logic [len_data-1:0] jr_address;
`endif
  logic                halt_in;
  logic [len_data-1:0] pc_out;
  logic [len_data-1:0] pc_next;
  logic [2:0]          PCSrc;
  logic                flush_if_id;
  logic                flush_id_ex;
  logic                halted;

  // Handshake: there is no valid/ready pair. Every request is a level that is
  // sampled on each rising clk edge; the PC owner always accepts it in that
  // same cycle, either applying it (advance=1), buffering it (advance=0), or
  // dropping it (lower priority than a buffered redirect, or in HALT).
  modport master (
    output enable, stall, branch_taken, branch_address, jump_req, jump_address,
`ifdef PC_JR_EN
    output jr_req, jr_address,
`endif
    output halt_in,
    input  pc_out, pc_next, PCSrc, flush_if_id, flush_id_ex, halted
  );

  modport slave (
    input  enable, stall, branch_taken, branch_address, jump_req, jump_address,
`ifdef PC_JR_EN
    input  jr_req, jr_address,
`endif
    input  halt_in,
    output pc_out, pc_next, PCSrc, flush_if_id, flush_id_ex, halted
  );
endinterface

// File: rtl/pc_control.sv
// Program-counter owner: redirect arbitration, pending-redirect buffer, halt.
// Optional register-jump source is enabled by defining PC_JR_EN.
module pc_control #(
  parameter int unsigned         len_data       = 32,
  parameter logic [len_data-1:0] pc_reset_value = '0,
  parameter int unsigned         pc_step        = 4
) (
  input  logic       clk,
  input  logic       reset,
  pc_if.slave        bus,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PEND = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam logic [2:0] SRC_SEQ = 3'b000;
  localparam logic [2:0] SRC_BR  = 3'b001;
  localparam logic [2:0] SRC_JR  = 3'b010;
  localparam logic [2:0] SRC_J   = 3'b100;

  state_t              state_q, state_d;
  logic [len_data-1:0] pc_q, pc_d;
  logic [2:0]          pend_src_q, pend_src_d;
  logic [len_data-1:0] pend_tgt_q, pend_tgt_d;

  logic                advance;
  logic                jr_req_w;
  logic [len_data-1:0] jr_addr_w;
  logic [2:0]          req_src;
  logic [len_data-1:0] req_tgt;
  logic                redirect;
  logic [len_data-1:0] pc_seq;
  logic [2:0]          src;
  logic                flush_if;
  logic                flush_ex;

  // Larger rank wins; used to decide whether a new request may replace a buffered one.
  function automatic logic [1:0] src_rank(input logic [2:0] s);
    case (s)
      SRC_BR:  src_rank = 2'd3;
      SRC_JR:  src_rank = 2'd2;
      SRC_J:   src_rank = 2'd1;
      default: src_rank = 2'd0;
    endcase
  endfunction

`ifdef PC_JR_EN
  assign jr_req_w  = bus.jr_req;
  assign jr_addr_w = bus.jr_address;
`else
  assign jr_req_w  = 1'b0;
  assign jr_addr_w = '0;
`endif

  assign advance  = bus.enable & ~bus.stall;
  assign pc_seq   = pc_q + len_data'(pc_step);
  assign redirect = |req_src;

  // The branch belongs to the oldest instruction, so it beats anything in ID.
  always_comb begin
    req_src = SRC_SEQ;
    req_tgt = '0;
    if (bus.branch_taken) begin
      req_src = SRC_BR;
      req_tgt = bus.branch_address;
    end else if (jr_req_w) begin
      req_src = SRC_JR;
      req_tgt = jr_addr_w;
    end else if (bus.jump_req) begin
      req_src = SRC_J;
      req_tgt = bus.jump_address;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_src_d = pend_src_q;
    pend_tgt_d = pend_tgt_q;
    src        = SRC_SEQ;
    flush_if   = 1'b0;
    flush_ex   = 1'b0;

    case (state_q)
      RUN: begin
        flush_if = redirect;
        flush_ex = (req_src == SRC_BR);
        if (advance && redirect) begin
          src  = req_src;
          pc_d = req_tgt;
        end else if (bus.halt_in && !redirect) begin
          state_d = HALT;
        end else if (advance) begin
          pc_d = pc_seq;
        end else if (redirect) begin
          state_d    = PEND;
          pend_src_d = req_src;
          pend_tgt_d = req_tgt;
        end
      end

      PEND: begin
        // Flushes here belong to newly seen requests; the buffered one already flushed.
        flush_if = redirect;
        flush_ex = (req_src == SRC_BR);
        if (advance) begin
          if (bus.branch_taken) begin
            src  = SRC_BR;
            pc_d = bus.branch_address;
          end else begin
            src  = pend_src_q;
            pc_d = pend_tgt_q;
          end
          state_d    = RUN;
          pend_src_d = SRC_SEQ;
          pend_tgt_d = '0;
        end else if (redirect && (src_rank(req_src) >= src_rank(pend_src_q))) begin
          pend_src_d = req_src;
          pend_tgt_d = req_tgt;
        end
      end

      HALT: begin
        state_d = HALT;
      end

      default: begin
        state_d    = RUN;
        pend_src_d = SRC_SEQ;
        pend_tgt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= RUN;
      pc_q       <= pc_reset_value;
      pend_src_q <= SRC_SEQ;
      pend_tgt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_src_q <= pend_src_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  assign bus.pc_out      = pc_q;
  assign bus.pc_next     = pc_seq;
  assign bus.PCSrc       = src;
  assign bus.flush_if_id = flush_if;
  assign bus.flush_id_ex = flush_ex;
  assign bus.halted      = (state_q == HALT);
  assign fsm_state       = state_q;

endmodule

// File: doc/pc_control.md
# pc_control

Program-counter owner for the pipelined MIPS core. Holds the PC register, arbitrates redirect requests (branch from EX/MEM, jump from ID, optional register jump), produces the one-hot `PCSrc` select and the next PC, and issues pipeline flushes. It buffers a redirect that arrives while fetch is frozen so the redirect is never lost. It also implements the halt state used by the debug unit.

## Interface
- `len_data`, 32, data/address width.
- `pc_reset_value`, 0, PC value loaded on reset.
- `pc_step`, 4, sequential increment.

- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-low reset. The block is reset on any rising `clk` edge where `reset`=0.
- `enable` in 1: debug step enable; 0 freezes the PC.
- `stall` in 1: hazard-unit stall; 1 freezes the PC.
- `branch_taken` in 1: resolved taken branch, from EX/MEM.
- `branch_address` in len_data: branch target.
- `jump_req` in 1: J/JAL decoded in ID.
- `jump_address` in len_data: jump target.
- `jr_req` in 1: JR/JALR decoded in ID. Only present with `PC_JR_EN`.
- `jr_address` in len_data: register target. Only present with `PC_JR_EN`.
- `halt_in` in 1: halt opcode decoded in ID.
- `pc_out` out len_data: current PC, registered.
- `pc_next` out len_data: `pc_out + pc_step`, combinational, used as the link value.
- `PCSrc` out 3: one-hot source applied at the next edge. 3'b100 = jump, 3'b010 = jr, 3'b001 = branch, 3'b000 = sequential.
- `flush_if_id` out 1: kill the IF/ID contents.
- `flush_id_ex` out 1: kill the ID/EX contents.
- `halted` out 1: the block is in the HALT state.

## Operation
- States:
  - RUN: normal operation.
  - PEND: a redirect is buffered.
  - HALT: the PC is frozen.
- `advance` = `enable` & !`stall`.
- Priority within a cycle: branch > jr > jump > halt > sequential. The branch belongs to the oldest instruction, so it overrides any younger ID request.
- RUN:
  - If `advance`=1: `pc_out` <= selected target. A sequential step is `pc_out+pc_step`, modulo 2^len_data; wrap from 0xFFFFFFFC to 0 is legal.
  - If `advance`=0 and a redirect is present: latch the target and kind into the pending register and go to PEND. `pc_out` holds.
  - If `halt_in` is present and no redirect is present: go to HALT. `pc_out` holds.
- PEND:
  - If `advance`=1: `pc_out` <= pending target, `PCSrc` = pending kind, go to RUN.
  - A new redirect while frozen is stored only if its priority is ≥ the pending kind (a branch overwrites a pending jump). A lower-priority request is dropped.
  - A new branch arriving in the same cycle that `advance`=1 wins over the pending redirect and is applied directly.
- HALT:
  - `pc_out` holds and `PCSrc`=000.
  - All requests are ignored.
  - Only reset exits HALT.
- Flushes, combinational in the cycle the request is seen, independent of `stall`/`enable`:
  - Branch: `flush_if_id`=1 and `flush_id_ex`=1.
  - Jr or jump: `flush_if_id`=1 only.
  - No flush is issued in HALT.
  - No flush is issued when a pending redirect is applied; it was already issued when the redirect was captured.
- `halt_in` together with `branch_taken`: the branch is applied and the halt is discarded, because the halt was on the wrong path.
- Reset mid-PEND or mid-HALT: the pending register is cleared and the state returns to RUN.

## Timing
- Reset values:
  - `pc_out` = `pc_reset_value`
  - state = RUN
  - pending register cleared
  - `halted`=0
  - `PCSrc`=000
  - both flush outputs 0
- The redirect takes effect on `pc_out` one edge after the request is sampled with `advance`=1. Latency is 1 cycle.
- A redirect buffered in PEND appears on `pc_out` one edge after `advance` returns to 1.
- `halted` asserts the edge after `halt_in` is accepted.
- `PCSrc`, `pc_next` and the flush outputs are combinational from the current state and inputs. `pc_out` and `halted` are registered.

## Configuration
- `PC_JR_EN` defined:
  - The `jr_req`/`jr_address` ports exist.
  - Source 3'b010 is selectable.
  - A jr request flushes IF/ID.
- `PC_JR_EN` undefined:
  - The ports are absent.
  - `PCSrc` never equals 3'b010.
  - The priority chain is branch > jump > halt > sequential.

## Test plan
- Reset and sequential stepping: hold `reset`=0 for 2 cycles, then release with `enable`=1 and no requests. `pc_out` reads 0, 4, 8, 12, and `PCSrc`=000 throughout.
- Branch vs jump collision: at PC=0x10, assert `branch_taken`=1 with `branch_address`=0x40 and `jump_req`=1 with `jump_address`=0x80 in the same cycle. Required: `PCSrc`=001, both flushes =1, next `pc_out`=0x40.
- Redirect during stall: assert `stall`=1 and `jump_req`=1 with `jump_address`=0x100. `flush_if_id`=1 that cycle and `pc_out` holds. Then assert `branch_taken` with `branch_address`=0x200 while still stalled. Release `stall`. Required: `pc_out`=0x200 one edge later, `PCSrc`=001 in the release cycle.
- Halt:
  - `halt_in`=1 at PC=0x20. Required: `halted`=1 next cycle, `pc_out` stays 0x20 for 10 cycles despite `jump_req`, then `reset`=0 returns PC to 0.
  - `halt_in` together with `branch_taken` to 0x60. Required: `halted`=0, `pc_out`=0x60.
- Wrap-around and `PC_JR_EN`:
  - Start from `pc_reset_value`=0xFFFFFFFC. Required: next `pc_out`=0.
  - With `PC_JR_EN` defined, `jr_req` with `jr_address`=0x300. Required: `PCSrc`=010, `flush_if_id`=1, `flush_id_ex`=0, `pc_out`=0x300.
